// File: rtl/step_phase_monitor.sv
// Debounces the 4-bit full-step phase bus and tracks step, direction, position, motion and sequence errors.
// Define STEP_MON_SYNC_EN to put a 2-flop synchronizer in front of the debounce filter.
module step_phase_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int POS_W         = 16,
    parameter int TIMEOUT       = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       signal_i,
    input  logic             clear_i,
    output logic             step_o,
    output logic             dir_o,
    output logic [POS_W-1:0] pos_o,
    output logic             moving_o,
    output logic             energized_o,
    output logic             err_o,
    output logic [7:0]       err_cnt_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W:0]   STABLE_V = (CNT_W + 1)'(STABLE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_OFF, S_HOLD, S_MOVE} state_t;

    state_t           state, state_next;
    logic [3:0]       sample, prev_sample, accepted;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W:0]   run_now;
    logic             accept, legal, is_off;
    logic [1:0]       new_idx, phase, phase_next, delta;
    logic [TMR_W-1:0] timer, timer_next;
    logic             do_step, step_fwd, err_ev;

`ifdef STEP_MON_SYNC_EN
    logic [3:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= signal_i;
            sync2 <= sync1;
        end
    end

    assign sample = sync2;
`else
    assign sample = signal_i;
`endif

    // run_cnt holds how many identical samples prev_sample has seen, saturating at STABLE_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sample <= '0;
            run_cnt     <= '0;
        end else if (sample != prev_sample) begin
            prev_sample <= sample;
            run_cnt     <= CNT_W'(1);
        end else if (run_cnt != STABLE_C) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    always_comb begin
        run_now = (sample == prev_sample) ? ({1'b0, run_cnt} + 1'b1) : (CNT_W + 1)'(1);
        accept  = (run_now >= STABLE_V) && (sample != accepted);
        legal   = 1'b1;
        new_idx = 2'd0;
        is_off  = (sample == 4'b0000);
        case (sample)
            4'b1001: new_idx = 2'd0;
            4'b1100: new_idx = 2'd1;
            4'b0110: new_idx = 2'd2;
            4'b0011: new_idx = 2'd3;
            default: legal = 1'b0;
        endcase
        delta = new_idx - phase;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_OFF;
            phase <= 2'd0;
            timer <= '0;
        end else begin
            state <= state_next;
            phase <= phase_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        phase_next = phase;
        timer_next = timer;
        do_step    = 1'b0;
        step_fwd   = 1'b0;
        err_ev     = 1'b0;
        case (state)
            S_OFF: begin
                if (accept && legal) begin
                    state_next = S_HOLD;
                    phase_next = new_idx;
                end else if (accept && !is_off) begin
                    err_ev = 1'b1;
                end
            end
            default: begin
                if (accept && legal) begin
                    phase_next = new_idx;
                    case (delta)
                        2'd1: begin do_step = 1'b1; step_fwd = 1'b1; end
                        2'd3: begin do_step = 1'b1; step_fwd = 1'b0; end
                        2'd2: err_ev = 1'b1;
                        default: ;
                    endcase
                    if (do_step) begin
                        state_next = S_MOVE;
                        timer_next = '0;
                    end
                end else if (accept) begin
                    state_next = S_OFF;
                    err_ev     = !is_off;
                end
                // A skip error leaves the motion timer running; only a real step reloads it.
                if (state == S_MOVE && !do_step && state_next == S_MOVE) begin
                    if (timer == TMR_LAST) state_next = S_HOLD;
                    else                   timer_next = timer + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accepted    <= '0;
            step_o      <= 1'b0;
            dir_o       <= 1'b0;
            pos_o       <= '0;
            moving_o    <= 1'b0;
            energized_o <= 1'b0;
            err_o       <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            if (accept) accepted <= sample;
            step_o      <= do_step;
            if (do_step) dir_o <= step_fwd;
            moving_o    <= (state_next == S_MOVE);
            energized_o <= (state_next != S_OFF);
            // clear_i takes priority over any step or error landing on the same edge.
            if (clear_i) begin
                pos_o     <= '0;
                err_o     <= 1'b0;
                err_cnt_o <= '0;
            end else begin
                if (do_step) pos_o <= step_fwd ? pos_o + 1'b1 : pos_o - 1'b1;
                if (err_ev) begin
                    err_o <= 1'b1;
                    if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_step_phase_monitor.sv
// Self-checking bench for step_phase_monitor: directed scenarios plus randomized phase traffic
// checked every cycle against a queue-based behavioural model.
module tb_step_phase_monitor;

    localparam int STABLE  = 4;
    localparam int POS_W   = 8;
    localparam int TIMEOUT = 200;
`ifdef STEP_MON_SYNC_EN
    localparam int LAT = STABLE + 2;
`else
    localparam int LAT = STABLE;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       signal_i;
    logic             clear_i;
    logic             step_o, dir_o, moving_o, energized_o, err_o;
    logic [POS_W-1:0] pos_o;
    logic [7:0]       err_cnt_o;

    step_phase_monitor #(.STABLE_CYCLES(STABLE), .POS_W(POS_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .signal_i(signal_i), .clear_i(clear_i),
        .step_o(step_o), .dir_o(dir_o), .pos_o(pos_o), .moving_o(moving_o),
        .energized_o(energized_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int step_seen = 0;
    bit chk_en = 1'b0;
    int cur_idx = 0;
    logic [3:0] PH [4] = '{4'b1001, 4'b1100, 4'b0110, 4'b0011};

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int phaseOf(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (PH[i] == p) return i;
        return (p == 4'b0000) ? 4 : 5;
    endfunction

    // Behavioural model: window of recent samples decides acceptance, phase moves are mod-4 distances.
    logic [3:0] hist [$];
    logic [3:0] m_acc, p1, p2, s;
    bit m_en, move_flag, m_step, m_dir, m_err, m_moving;
    int m_phase, m_ecnt, cyc, last_step;
    logic [POS_W-1:0] m_pos;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            hist.delete();
            m_acc = 0; m_en = 0; m_phase = 0; move_flag = 0; m_step = 0; m_dir = 0;
            m_pos = 0; m_err = 0; m_ecnt = 0; m_moving = 0; p1 = 0; p2 = 0;
        end else begin
            bit same, err_ev;
            int idx, d;
            s = signal_i;
`ifdef STEP_MON_SYNC_EN
            s = p2; p2 = p1; p1 = signal_i;
`endif
            hist.push_back(s);
            if (hist.size() > STABLE) void'(hist.pop_front());
            same = (hist.size() == STABLE);
            foreach (hist[i]) if (hist[i] != s) same = 0;
            m_step = 0; err_ev = 0;
            if (same && s != m_acc) begin
                m_acc = s;
                idx = phaseOf(s);
                if (!m_en) begin
                    if (idx < 4) begin m_en = 1; m_phase = idx; move_flag = 0; end
                    else if (idx == 5) err_ev = 1;
                end else if (idx < 4) begin
                    d = (idx - m_phase + 4) % 4;
                    if (d == 1)      begin m_step = 1; m_dir = 1; m_pos = m_pos + 1; end
                    else if (d == 3) begin m_step = 1; m_dir = 0; m_pos = m_pos - 1; end
                    else if (d == 2) err_ev = 1;
                    m_phase = idx;
                end else begin
                    m_en = 0; move_flag = 0;
                    err_ev = (idx == 5);
                end
            end
            if (m_step) begin last_step = cyc; move_flag = 1; end
            if (clear_i) begin
                m_pos = 0; m_err = 0; m_ecnt = 0;
            end else if (err_ev) begin
                m_err = 1;
                if (m_ecnt < 255) m_ecnt++;
            end
            m_moving = move_flag && ((cyc - last_step) < TIMEOUT);
        end
    end

    always @(negedge clk) begin
        if (step_o === 1'b1) step_seen++;
        if (chk_en) begin
            checkOutput("m_step", step_o, m_step);
            checkOutput("m_dir", dir_o, m_dir);
            checkOutput("m_pos", pos_o, m_pos);
            checkOutput("m_moving", moving_o, m_moving);
            checkOutput("m_energized", energized_o, m_en);
            checkOutput("m_err", err_o, m_err);
            checkOutput("m_err_cnt", err_cnt_o, m_ecnt);
        end
    end

    task automatic applyStimulus(input logic [3:0] pat, input int n);
        signal_i = pat;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseClear();
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    task automatic stepFwd();
        cur_idx = (cur_idx + 1) % 4;
        applyStimulus(PH[cur_idx], 5);
    endtask

    initial begin
        int steps_before;
        rst = 1'b1; signal_i = 4'b0000; clear_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        checkOutput("reset_pos", pos_o, 0);
        checkOutput("reset_energized", energized_o, 0);
        checkOutput("reset_err_cnt", err_cnt_o, 0);

        // Lock onto P0 without stepping
        applyStimulus(4'b1001, 10);
        checkOutput("lock_energized", energized_o, 1);
        checkOutput("lock_pos", pos_o, 0);
        checkOutput("lock_no_step", step_seen, 0);

        // Four forward steps with latency check
        for (int k = 0; k < 4; k++) begin
            cur_idx = (cur_idx + 1) % 4;
            signal_i = PH[cur_idx];
            repeat (LAT - 1) @(negedge clk);
            checkOutput("lat_early", step_o, 0);
            @(negedge clk);
            checkOutput("lat_pulse", step_o, 1);
            repeat (6) @(negedge clk);
        end
        checkOutput("fwd_steps", step_seen, 4);
        checkOutput("fwd_pos", pos_o, 4);
        checkOutput("fwd_dir", dir_o, 1);
        checkOutput("fwd_moving", moving_o, 1);
        repeat (TIMEOUT + 5) @(negedge clk);
        checkOutput("timeout_moving", moving_o, 0);

        // Reverse two steps, then a short glitch
        pulseClear();
        cur_idx = 3; applyStimulus(PH[3], 10);
        cur_idx = 2; applyStimulus(PH[2], 10);
        checkOutput("rev_dir", dir_o, 0);
        checkOutput("rev_pos", $signed(pos_o), -2);
        steps_before = step_seen;
        applyStimulus(4'b1100, 2);
        applyStimulus(PH[2], 10);
        checkOutput("glitch_pos", $signed(pos_o), -2);
        checkOutput("glitch_steps", step_seen, steps_before);

        // Skip and illegal errors, then saturation
        stepFwd(); stepFwd();
        pulseClear();
        steps_before = step_seen;
        cur_idx = 2; applyStimulus(PH[2], 10);
        checkOutput("skip_err", err_o, 1);
        checkOutput("skip_cnt", err_cnt_o, 1);
        checkOutput("skip_no_step", step_seen, steps_before);
        applyStimulus(4'b1010, 10);
        checkOutput("illegal_cnt", err_cnt_o, 2);
        checkOutput("illegal_energized", energized_o, 0);
        for (int k = 0; k < 300; k++) applyStimulus((k % 2) ? 4'b1010 : 4'b0101, 5);
        checkOutput("sat_cnt", err_cnt_o, 255);

        // Position wrap and clear on a step edge
        applyStimulus(4'b0000, 10);
        pulseClear();
        cur_idx = 0; applyStimulus(PH[0], 10);
        for (int k = 0; k < 127; k++) stepFwd();
        checkOutput("max_pos", $signed(pos_o), 127);
        stepFwd();
        checkOutput("wrap_pos", $signed(pos_o), -128);
        cur_idx = (cur_idx + 1) % 4;
        signal_i = PH[cur_idx];
        repeat (LAT - 1) @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        checkOutput("clr_step_pulse", step_o, 1);
        checkOutput("clr_step_pos", pos_o, 0);
        repeat (4) @(negedge clk);

        // Reset mid-motion, then re-lock without a step
        stepFwd();
        cur_idx = (cur_idx + 1) % 4;
        signal_i = PH[cur_idx];
        repeat (LAT) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_moving", moving_o, 0);
        checkOutput("rst_energized", energized_o, 0);
        checkOutput("rst_pos", pos_o, 0);
        checkOutput("rst_dir", dir_o, 0);
        steps_before = step_seen;
        applyStimulus(PH[cur_idx], 10);
        checkOutput("relock_energized", energized_o, 1);
        checkOutput("relock_steps", step_seen, steps_before);

        // Randomized traffic, model-checked every cycle
        for (int k = 0; k < 600; k++) begin
            int r = $urandom_range(0, 99);
            logic [3:0] pat;
            if (r < 40)      begin cur_idx = (cur_idx + 1) % 4; pat = PH[cur_idx]; end
            else if (r < 70) begin cur_idx = (cur_idx + 3) % 4; pat = PH[cur_idx]; end
            else if (r < 78) begin cur_idx = (cur_idx + 2) % 4; pat = PH[cur_idx]; end
            else             pat = 4'($urandom_range(0, 15));
            clear_i = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 149) == 0);
            signal_i = pat;
            @(negedge clk);
            clear_i = 1'b0;
            rst     = 1'b0;
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
